sum_splitter: RTL and testbench

SUM_SPLITTER -- requirements
Module: sum_splitter

---
 rtl/adder_pkg.sv | 16 +
 rtl/sum_splitter.sv | 101 ++++++++++
 tb/tb_sum_splitter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM state encoding, operand count
// and the operand saturation value derived from a width.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int NUM_OPS = 4;

  function automatic int max_from_width(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/sum_splitter.sv
// Splits one accepted sum into four saturating operand beats (a, b, c, d),
// greedily filling each beat up to MAX before moving to the next.
module sum_splitter #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = adder_pkg::NUM_OPS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH+1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             out_err,
  output logic             o_dbg_state
);
  import adder_pkg::*;

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(max_from_width(WIDTH));
  localparam logic [WIDTH+1:0] LIMIT    = (WIDTH+2)'(NUM_OPS * max_from_width(WIDTH));
  localparam logic [1:0]       LAST_IDX = 2'(NUM_OPS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its payload stable until that edge.
  state_t           r_state;
  logic [WIDTH+1:0] r_rem;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_idx;
  logic             r_last;
  logic             r_err;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [WIDTH+1:0] w_rem_sub;

  function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+1:0] x);
    return (x > {2'b00, MAX_W}) ? MAX_W : x[WIDTH-1:0];
  endfunction

  // The beat on the bus never exceeds the remainder, so this cannot wrap.
  assign w_rem_sub = r_rem - {2'b00, r_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_data      <= '0;
      r_idx       <= '0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state     <= SEND;
            r_rem       <= in_sum;
            r_data      <= sat(in_sum);
            r_idx       <= '0;
            r_last      <= (LAST_IDX == 2'd0);
            r_err       <= (in_sum > LIMIT);
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
          end
        end
        SEND: begin
          if (out_ready) begin
            r_rem <= w_rem_sub;
            if (r_idx == LAST_IDX) begin
              // Any residue left over an error sum is dropped here.
              r_state     <= IDLE;
              r_data      <= '0;
              r_idx       <= '0;
              r_last      <= 1'b0;
              r_err       <= 1'b0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_data <= sat(w_rem_sub);
              r_idx  <= r_idx + 2'd1;
              r_last <= ((r_idx + 2'd1) == LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_data;
  assign out_idx     = r_idx;
  assign out_last    = r_last;
  assign out_err     = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sum_splitter.sv
// Bench for sum_splitter: directed scenarios plus a randomized run, checked
// against a reference split computed from the greedy saturating rule.
module tb_sum_splitter;
  localparam int WIDTH = 4;
  localparam int MAX   = 15;
  localparam int W     = 8;  // packed beat: {data[3:0], idx[1:0], last, err}

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH+1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_idx;
  logic             out_last;
  logic             out_err;
  logic             dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  sum_splitter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_err(out_err), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference: greedy split of the sum into four operands of at most MAX
  task automatic build_exp(input int s);
    int rem;
    int d;
    logic e;
    logic [3:0] d4;
    logic [1:0] i2;
    exp_q.delete();
    rem = s;
    e = (s > 4 * MAX);
    for (int i = 0; i < 4; i++) begin
      d = (rem > MAX) ? MAX : rem;
      d4 = 4'(d);
      i2 = 2'(i);
      exp_q.push_back({d4, i2, (i == 3), e});
      rem = rem - d;
    end
  endtask

  // driver: present a sum and hold it until accepted
  task automatic accept(input int s, output int ok);
    int n;
    ok = 0;
    n = 0;
    @(negedge clk);
    in_sum = 6'(s);
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready) ok = 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sum = 6'($urandom_range(0, 63));
  endtask

  // driver: stall the sink for `stall` valid cycles, then take one beat
  task automatic get_beat(input int stall, output logic [W-1:0] got, output int waited);
    int n;
    int seen;
    logic found;
    n = 0;
    seen = 0;
    found = 1'b0;
    got = '0;
    waited = -1;
    while (!found && n < 50) begin
      @(negedge clk);
      if (out_valid && seen >= stall) begin
        out_ready = 1'b1;
        got = {out_data, out_idx, out_last, out_err};
        waited = n;
        found = 1'b1;
      end else begin
        out_ready = 1'b0;
        if (out_valid) seen++;
      end
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sum = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, out_data, out_idx, out_last, out_err, dbg_state} !== 11'b01_0000_00_0_0_0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b r=%b d=%0d i=%0d l=%b e=%b st=%b", out_valid, in_ready,
               out_data, out_idx, out_last, out_err, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
    end
  endtask

  // one sum with an always-ready sink; beats must be back-to-back
  task automatic run_sum(input string name, input int s);
    logic [W-1:0] got;
    int waited;
    int ok;
    build_exp(s);
    accept(s, ok);
    n_checks++;
    if (ok != 1) begin
      n_fail++;
      $display("FAIL %s_accept in_ready never high", name);
    end
    for (int i = 0; i < 4; i++) begin
      get_beat(0, got, waited);
      n_checks++;
      if (waited != 0 || got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_beat%0d got %h (wait %0d) want %h (wait 0)", name, i, got, waited, exp_q[i]);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data, out_idx, out_last, out_err} !== 10'b10_0000_00_0_0) begin
      n_fail++;
      $display("FAIL %s_idle_after got r=%b v=%b d=%0d i=%0d l=%b e=%b want r=1 v=0 rest 0",
               name, in_ready, out_valid, out_data, out_idx, out_last, out_err);
    end
  endtask

  task automatic test_full;       run_sum("full60", 60); endtask
  task automatic test_partial;    run_sum("part17", 17); endtask
  task automatic test_zero;       run_sum("zero", 0);    endtask
  task automatic test_err;        run_sum("err63", 63);  endtask

  task automatic test_backpressure;
    logic [W-1:0] got;
    int waited;
    int ok;
    build_exp(20);
    accept(20, ok);
    get_beat(0, got, waited);
    n_checks++;
    if (got !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_beat0 got %h want %h", got, exp_q[0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      n_checks++;
      if ({out_valid, out_data, out_idx, out_last, out_err} !== {1'b1, exp_q[1]}) begin
        n_fail++;
        $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", k, out_valid,
                 {out_data, out_idx, out_last, out_err}, exp_q[1]);
      end
    end
    for (int i = 1; i < 4; i++) begin
      get_beat(0, got, waited);
      n_checks++;
      if (waited < 0 || got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_beat%0d got %h want %h", i, got, exp_q[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] got;
    int waited;
    int ok;
    build_exp(45);
    accept(45, ok);
    get_beat(0, got, waited);
    get_beat(0, got, waited);
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_idx !== 2'd2 || dbg_state !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got v=%b i=%0d st=%b want v=1 i=2 st=1", out_valid, out_idx, dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, out_data, out_idx, out_err} !== 9'b01_0000_00_0) begin
      n_fail++;
      $display("FAIL rstmid_drop got v=%b r=%b d=%0d i=%0d e=%b want v=0 r=1 rest 0",
               out_valid, in_ready, out_data, out_idx, out_err);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_nobeat%0d got v=%b want v=0", k, out_valid);
      end
    end
    run_sum("after_rst30", 30);
  endtask

  // randomized sums with random sink stalls; beats are re-added and compared
  task automatic test_random;
    logic [W-1:0] got;
    int waited;
    int ok;
    int s;
    int total;
    for (int t = 0; t < 40; t++) begin
      s = (t % 8 == 0) ? 60 : int'($urandom_range(0, 60));
      build_exp(s);
      accept(s, ok);
      total = 0;
      for (int i = 0; i < 4; i++) begin
        get_beat(int'($urandom_range(0, 2)), got, waited);
        total = total + int'(got[7:4]);
        n_checks++;
        if (waited < 0 || got !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d sum=%0d got %h want %h", t, i, s, got, exp_q[i]);
        end
      end
      n_checks++;
      if (total != s) begin
        n_fail++;
        $display("FAIL rand%0d_total got %0d want %0d", t, total, s);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial();
    test_zero();
    test_err();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
